// File: rtl/apb_regbank_slave_pkg.sv
// apb_regbank_slave_pkg: shared FSM state, error codes and index-width helper for the APB register bank.
package apb_regbank_slave_pkg;
   typedef enum logic {IDLE, ACCESS} state_e;
   typedef enum logic [1:0] {ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_RO} err_e;
   function automatic int idxw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/apb_regbank_slave_reg_file.sv
// apb_regbank_slave_reg_file: word registers with byte-strobe writes; RO slots mirror fabric data.
module apb_regbank_slave_reg_file
   import apb_regbank_slave_pkg::*;
#(
   parameter int                  DW        = 32,
   parameter int                  NUM_REGS  = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
   parameter logic [DW-1:0]       RESET_VAL = '0,
   parameter int                  IDXW      = idxw(NUM_REGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we_i,
   input  logic [IDXW-1:0]        idx_i,
   input  logic [DW-1:0]          wdata_i,
   input  logic [DW/8-1:0]        strb_i,
   input  logic [NUM_REGS*DW-1:0] hw_rdata_i,
   output logic [NUM_REGS*DW-1:0] reg_out_o
);
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      logic [DW-1:0] q;
      always_ff @(posedge clk)
         if (rst) q <= RESET_VAL;
         else if (we_i && idx_i == IDXW'(r) && !RO_MASK[r])
            for (int b = 0; b < DW/8; b++)
               if (strb_i[b]) q[8*b +: 8] <= wdata_i[8*b +: 8];
      assign reg_out_o[r*DW +: DW] = RO_MASK[r] ? hw_rdata_i[r*DW +: DW] : q;
   end
endmodule

// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB4 register-bank slave with wait states, byte strobes and PSLVERR decode.
// One guard bit above the index field flags the first aliased window as out of range.
module apb_regbank_slave
   import apb_regbank_slave_pkg::*;
#(
   parameter int                  DW          = 32,
   parameter int                  AW          = 32,
   parameter int                  NUM_REGS    = 8,
   parameter int                  WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
   parameter logic [DW-1:0]       RESET_VAL   = '0
) (
   input  logic                   PCLK,
   input  logic                   PRESET,
   input  logic [AW-1:0]          PADDR,
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic                   PWRITE,
   input  logic [DW-1:0]          PWDATA,
   input  logic [DW/8-1:0]        PSTRB,
   output logic                   PREADY,
   output logic                   PSLVERR,
   output logic [DW-1:0]          PRDATA,
   input  logic [NUM_REGS*DW-1:0] HW_RDATA,
   output logic [NUM_REGS*DW-1:0] REG_OUT
);
   localparam int IDXW = idxw(NUM_REGS);
   state_e          state_q;
   err_e            err_q, err_d;
   logic [IDXW-1:0] idx_q;
   logic            write_q;
   logic [DW-1:0]   wdata_q, prdata_q, rd_val;
   logic [DW/8-1:0] strb_q;
   logic [3:0]      cnt_q;
   logic [IDXW:0]   idx_ext;
   logic            commit;
   logic            unused_addr;
   assign idx_ext     = PADDR[IDXW+2:2];
   assign unused_addr = ^PADDR[AW-1:IDXW+3];
   always_comb begin
      err_d  = PADDR[1:0] != 2'b00 ? ERR_ALIGN :
               idx_ext >= (IDXW+1)'(NUM_REGS) ? ERR_RANGE :
               (PWRITE && RO_MASK[idx_ext[IDXW-1:0]]) ? ERR_RO : ERR_NONE;
      rd_val = REG_OUT[int'(idx_ext[IDXW-1:0])*DW +: DW];
   end
   assign commit = state_q == ACCESS && PSEL && PENABLE && cnt_q == 4'd0 &&
                   write_q && err_q == ERR_NONE;
   always_ff @(posedge PCLK)
      if (PRESET) begin
         state_q  <= IDLE;
         err_q    <= ERR_NONE;
         idx_q    <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strb_q   <= '0;
         cnt_q    <= '0;
         prdata_q <= '0;
      end else if (state_q == IDLE) begin
         if (PSEL && !PENABLE) begin
            state_q <= ACCESS;
            idx_q   <= idx_ext[IDXW-1:0];
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            cnt_q   <= 4'(WAIT_STATES);
            err_q   <= err_d;
            if (!PWRITE) prdata_q <= err_d == ERR_NONE ? rd_val : '0;
         end
      end else if (!PSEL) state_q <= IDLE;
      else if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      else state_q <= IDLE;
   assign PREADY  = state_q == ACCESS && cnt_q == 4'd0;
   assign PSLVERR = PREADY && err_q != ERR_NONE;
   assign PRDATA  = prdata_q;
   apb_regbank_slave_reg_file #(
      .DW(DW), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK), .RESET_VAL(RESET_VAL), .IDXW(IDXW)
   ) u_reg_file (
      .clk(PCLK),
      .rst(PRESET),
      .we_i(commit),
      .idx_i(idx_q),
      .wdata_i(wdata_q),
      .strb_i(strb_q),
      .hw_rdata_i(HW_RDATA),
      .reg_out_o(REG_OUT)
   );
endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb_apb_regbank_slave: directed APB transfers against hand-computed register contents.
module tb_apb_regbank_slave;
   logic         PCLK, PRESET, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0]  PADDR, PWDATA, PRDATA;
   logic [3:0]   PSTRB;
   logic [255:0] HW_RDATA, REG_OUT;
   int           n_cmp, n_bad;
   logic [31:0]  rd;
   logic         er;
   int           acc;
   apb_regbank_slave #(
      .DW(32), .AW(32), .NUM_REGS(8), .WAIT_STATES(1), .RO_MASK(8'hC0), .RESET_VAL(32'h0)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .PRDATA(PRDATA), .HW_RDATA(HW_RDATA), .REG_OUT(REG_OUT)
   );
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;
   // Entered and left at #1 after a rising edge; PSEL is left high so a next call is back-to-back.
   task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdata, output logic err,
                          output int cycles);
      PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge PCLK); #1 PENABLE = 1'b1;
      for (cycles = 1; cycles <= 20; cycles++) begin
         @(negedge PCLK);
         if (PREADY) break;
         @(posedge PCLK); #1;
      end
      rdata = PRDATA; err = PSLVERR;
      @(posedge PCLK); #1;
   endtask
   task automatic idle();
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
   endtask
   task automatic test_reset();
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; PSTRB = '0; HW_RDATA = '0;
      @(posedge PCLK); #1 PRESET = 1'b0;
      @(negedge PCLK);
      n_cmp++; if (PREADY !== 1'b0) begin n_bad++; $display("FAIL reset_pready got %b exp 0", PREADY); end
      n_cmp++; if (PSLVERR !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr got %b exp 0", PSLVERR); end
      n_cmp++; if (PRDATA !== 32'h0) begin n_bad++; $display("FAIL reset_prdata got %h exp 0", PRDATA); end
      n_cmp++; if (REG_OUT !== 256'h0) begin n_bad++; $display("FAIL reset_reg_out got %h exp 0", REG_OUT); end
      @(posedge PCLK); #1;
   endtask
   task automatic test_write_read();
      do_xfer(32'h08, 1'b1, 32'h0000000A, 4'hF, rd, er, acc);
      n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL wr08_latency got %0d exp 2", acc); end
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL wr08_err got %b exp 0", er); end
      idle();
      do_xfer(32'h08, 1'b0, 32'h0, 4'h0, rd, er, acc);
      n_cmp++; if (rd !== 32'h0000000A) begin n_bad++; $display("FAIL rd08_data got %h exp 0000000a", rd); end
      n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL rd08_latency got %0d exp 2", acc); end
      idle();
      do_xfer(32'h00, 1'b0, 32'h0, 4'h0, rd, er, acc);
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rd00_data got %h exp 0", rd); end
      idle();
   endtask
   task automatic test_strobe();
      do_xfer(32'h04, 1'b1, 32'hAABBCCDD, 4'b0101, rd, er, acc);
      idle();
      n_cmp++; if (REG_OUT[63:32] !== 32'h00BB00DD) begin n_bad++; $display("FAIL strb_reg1 got %h exp 00bb00dd", REG_OUT[63:32]); end
      do_xfer(32'h04, 1'b0, 32'h0, 4'h0, rd, er, acc);
      n_cmp++; if (rd !== 32'h00BB00DD) begin n_bad++; $display("FAIL strb_rd04 got %h exp 00bb00dd", rd); end
      do_xfer(32'h04, 1'b1, 32'h11111111, 4'h0, rd, er, acc);
      idle();
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL strb0_err got %b exp 0", er); end
      n_cmp++; if (REG_OUT[63:32] !== 32'h00BB00DD) begin n_bad++; $display("FAIL strb0_reg1 got %h exp 00bb00dd", REG_OUT[63:32]); end
   endtask
   task automatic test_errors();
      HW_RDATA[6*32 +: 32] = 32'h66666666;
      do_xfer(32'h18, 1'b1, 32'hFFFFFFFF, 4'hF, rd, er, acc);
      idle();
      n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL ro_wr_err got %b exp 1", er); end
      n_cmp++; if (REG_OUT[223:192] !== 32'h66666666) begin n_bad++; $display("FAIL ro_wr_reg6 got %h exp 66666666", REG_OUT[223:192]); end
      do_xfer(32'h20, 1'b0, 32'h0, 4'h0, rd, er, acc);
      idle();
      n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL range_rd_err got %b exp 1", er); end
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL range_rd_data got %h exp 0", rd); end
      do_xfer(32'h02, 1'b1, 32'hFFFFFFFF, 4'hF, rd, er, acc);
      idle();
      n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL align_wr_err got %b exp 1", er); end
      n_cmp++; if (REG_OUT[31:0] !== 32'h0) begin n_bad++; $display("FAIL align_wr_reg0 got %h exp 0", REG_OUT[31:0]); end
   endtask
   task automatic test_ro_read();
      HW_RDATA[7*32 +: 32] = 32'h12345678;
      do_xfer(32'h1C, 1'b0, 32'h0, 4'h0, rd, er, acc);
      idle();
      n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL ro_rd_data got %h exp 12345678", rd); end
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL ro_rd_err got %b exp 0", er); end
   endtask
   task automatic test_abort();
      PADDR = 32'h0C; PWRITE = 1'b1; PWDATA = 32'hDEADBEEF; PSTRB = 4'hF; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK);
      n_cmp++; if (PREADY !== 1'b0) begin n_bad++; $display("FAIL abort_pready got %b exp 0", PREADY); end
      @(posedge PCLK); #1;
      n_cmp++; if (REG_OUT[127:96] !== 32'h0) begin n_bad++; $display("FAIL abort_reg3 got %h exp 0", REG_OUT[127:96]); end
      do_xfer(32'h0C, 1'b1, 32'h00000033, 4'hF, rd, er, acc);
      idle();
      n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL after_abort_latency got %0d exp 2", acc); end
      n_cmp++; if (REG_OUT[127:96] !== 32'h00000033) begin n_bad++; $display("FAIL after_abort_reg3 got %h exp 00000033", REG_OUT[127:96]); end
   endtask
   task automatic test_back_to_back();
      do_xfer(32'h10, 1'b1, 32'h00000011, 4'hF, rd, er, acc);
      do_xfer(32'h10, 1'b0, 32'h0, 4'h0, rd, er, acc);
      n_cmp++; if (rd !== 32'h00000011) begin n_bad++; $display("FAIL b2b_rd10 got %h exp 00000011", rd); end
      n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL b2b_latency got %0d exp 2", acc); end
      do_xfer(32'h08, 1'b0, 32'h0, 4'h0, rd, er, acc);
      idle();
      n_cmp++; if (rd !== 32'h0000000A) begin n_bad++; $display("FAIL b2b_rd08 got %h exp 0000000a", rd); end
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL b2b_err got %b exp 0", er); end
   endtask
   initial begin
      n_cmp = 0; n_bad = 0;
      test_reset();
      test_write_read();
      test_strobe();
      test_errors();
      test_ro_read();
      test_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
